// File: rtl/memoria_de_programa_if.sv
// Instruction fetch and boot-loader bus between the control unit / byte source and the program memory.
// Handshake: a loader byte transfers on a rising clock edge where i_Load_Valid and o_Load_Ready are both high.
interface memoria_de_programa_if #(
    parameter int ADDR_W  = 9,
    parameter int INSTR_W = 9
);
    logic [ADDR_W-1:0]  i_Address_Bus;
    logic [INSTR_W-1:0] o_Instruction;
    logic               i_Load_Start;
    logic [7:0]         i_Load_Byte;
    logic               i_Load_Valid;
    logic               o_Load_Ready;
    logic               o_Hold;
    logic               o_Load_Done;
    logic               o_Load_Error;

    modport master (
        output i_Address_Bus, i_Load_Start, i_Load_Byte, i_Load_Valid,
        input  o_Instruction, o_Load_Ready, o_Hold, o_Load_Done, o_Load_Error
    );

    modport slave (
        input  i_Address_Bus, i_Load_Start, i_Load_Byte, i_Load_Valid,
        output o_Instruction, o_Load_Ready, o_Hold, o_Load_Done, o_Load_Error
    );
endinterface

// File: rtl/memoria_de_programa.sv
// MicroUAZ program memory: 1-cycle instruction fetch plus a byte-stream boot loader that stalls the core.
// Optional trailing XOR checksum byte enabled by defining LOAD_CHECKSUM_EN.
module memoria_de_programa #(
    parameter int                 ADDR_W   = 9,
    parameter int                 INSTR_W  = 9,
    parameter int                 DEPTH    = 512,
    parameter logic [INSTR_W-1:0] NOP_WORD = {INSTR_W{1'b0}}
) (
    input  logic                  i_Clk,
    input  logic                  i_Reset,
    memoria_de_programa_if.slave  bus,
    output logic [2:0]            fsm_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CNT_LO = 3'd1,
        S_CNT_HI = 3'd2,
        S_W_LO   = 3'd3,
        S_W_HI   = 3'd4,
        S_CHK    = 3'd5,
        S_DONE   = 3'd6
    } state_t;

`ifdef LOAD_CHECKSUM_EN
    localparam bit HAS_CHK = 1'b1;
`else
    localparam bit HAS_CHK = 1'b0;
`endif

    state_t             state;
    logic               hold_q;
    logic               ready_q;
    logic               done_q;
    logic [8:0]         remaining;
    logic [ADDR_W-1:0]  wr_ptr;
    logic [7:0]         lo_byte;
    logic [INSTR_W-1:0] instr_q;
    logic [INSTR_W-1:0] ram [DEPTH];

    logic               accept;
    logic               start;
    logic               ram_we;
    logic [INSTR_W-1:0] wr_data;

    assign accept  = bus.i_Load_Valid & ready_q;
    assign start   = (state == S_IDLE) & bus.i_Load_Start;
    assign ram_we  = accept & (state == S_W_HI);
    assign wr_data = INSTR_W'({bus.i_Load_Byte[0], lo_byte});

    assign bus.o_Instruction = instr_q;
    assign bus.o_Load_Ready  = ready_q;
    assign bus.o_Hold        = hold_q;
    assign bus.o_Load_Done   = done_q;
    assign fsm_state         = state;

    // Program RAM is deliberately not reset so a reset keeps the loaded image.
    always_ff @(posedge i_Clk) begin
        if (ram_we) begin
            ram[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            instr_q <= NOP_WORD;
        end else if (hold_q) begin
            instr_q <= NOP_WORD;
        end else begin
            instr_q <= ram[bus.i_Address_Bus];
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state     <= S_IDLE;
            hold_q    <= 1'b0;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            remaining <= '0;
            wr_ptr    <= '0;
            lo_byte   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_CNT_LO;
                        hold_q  <= 1'b1;
                        ready_q <= 1'b1;
                    end
                end
                S_CNT_LO: begin
                    if (accept) begin
                        remaining[7:0] <= bus.i_Load_Byte;
                        state          <= S_CNT_HI;
                    end
                end
                S_CNT_HI: begin
                    if (accept) begin
                        remaining[8] <= bus.i_Load_Byte[0];
                        wr_ptr       <= '0;
                        if ({bus.i_Load_Byte[0], remaining[7:0]} == 9'd0) begin
                            if (HAS_CHK) begin
                                state <= S_CHK;
                            end else begin
                                state   <= S_DONE;
                                ready_q <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            state <= S_W_LO;
                        end
                    end
                end
                S_W_LO: begin
                    if (accept) begin
                        lo_byte <= bus.i_Load_Byte;
                        state   <= S_W_HI;
                    end
                end
                S_W_HI: begin
                    // The RAM write happens on this same edge through ram_we.
                    if (accept) begin
                        wr_ptr    <= wr_ptr + ADDR_W'(1);
                        remaining <= remaining - 9'd1;
                        if (remaining == 9'd1) begin
                            if (HAS_CHK) begin
                                state <= S_CHK;
                            end else begin
                                state   <= S_DONE;
                                ready_q <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            state <= S_W_LO;
                        end
                    end
                end
`ifdef LOAD_CHECKSUM_EN
                S_CHK: begin
                    if (accept) begin
                        state   <= S_DONE;
                        ready_q <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
`endif
                S_DONE: begin
                    hold_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    state   <= S_IDLE;
                    hold_q  <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef LOAD_CHECKSUM_EN
    logic [7:0] csum;
    logic       error_q;

    // Running XOR covers every image byte, count bytes included; the CHK byte is compared against it.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            csum    <= '0;
            error_q <= 1'b0;
        end else if (start) begin
            csum    <= '0;
            error_q <= 1'b0;
        end else if (accept) begin
            if (state == S_CHK) begin
                if (bus.i_Load_Byte != csum) begin
                    error_q <= 1'b1;
                end
            end else begin
                csum <= csum ^ bus.i_Load_Byte;
            end
        end
    end

    assign bus.o_Load_Error = error_q;
`else
    assign bus.o_Load_Error = 1'b0;
`endif

endmodule

// File: doc/memoria_de_programa.md
Name: memoria_de_programa

Overview:
- Instruction-side responder for the MicroUAZ control unit: takes the 9-bit instruction address the control unit's jump/PC logic drives and returns the 9-bit instruction word that the decoder consumes.
- Holds program RAM plus a byte-stream boot loader FSM that writes a program image into RAM and stalls the core while loading.
- Sits between the control module and the external byte source (UART receiver or test bench).

Parameters:
- ADDR_W, 9, instruction address width.
- INSTR_W, 9, instruction word width.
- DEPTH, 512, number of RAM words (2**ADDR_W).
- NOP_WORD, 9'h000, word driven on o_Instruction while o_Hold is high.

Ports:
- i_Clk  in  1  system clock, rising edge.
- i_Reset  in  1  asynchronous, active-high reset.
- i_Address_Bus  in  9  instruction address from the control unit.
- o_Instruction  out  9  instruction word to the decoder.
- i_Load_Start  in  1  single-cycle pulse that starts a load.
- i_Load_Byte  in  8  loader data byte.
- i_Load_Valid  in  1  i_Load_Byte is valid this cycle.
- o_Load_Ready  out  1  loader accepts a byte this cycle; a byte transfers when valid and ready are both high.
- o_Hold  out  1  core stall, high from accepted start through done.
- o_Load_Done  out  1  one-cycle pulse when a load finishes.
- o_Load_Error  out  1  sticky checksum error (macro only; tied 0 otherwise).

Behaviour:
- Reset: FSM enters IDLE. o_Instruction=NOP_WORD, o_Hold=0, o_Load_Ready=0, o_Load_Done=0, o_Load_Error=0, internal counters=0. RAM contents are not reset.
- Fetch: o_Instruction <= RAM[i_Address_Bus] on every rising edge while o_Hold=0, giving exactly 1-cycle latency. While o_Hold=1, o_Instruction <= NOP_WORD.
- FSM states: IDLE, CNT_LO, CNT_HI, W_LO, W_HI, (CHK), DONE.
- IDLE: o_Load_Ready=0. i_Load_Start=1 -> CNT_LO with o_Hold=1 on the next cycle.
- CNT_LO: on accepted byte, count[7:0]=byte -> CNT_HI.
- CNT_HI: on accepted byte, count[8]=byte[0] (byte[7:1] ignored) and wr_ptr=0. Next state: count==0 -> DONE (or CHK), else W_LO.
- W_LO: on accepted byte, latch lo -> W_HI.
- W_HI: on accepted byte, write RAM[wr_ptr]={byte[0],lo} in that cycle, then wr_ptr+1 and remaining-1. Remaining==1 -> DONE (or CHK), else W_LO.
- DONE: one cycle. o_Load_Done=1 and o_Hold=0 from the next cycle -> IDLE.
- o_Load_Ready=1 in every state that is waiting for a byte; it drops in IDLE and DONE. Bytes with i_Load_Valid=1 while ready=0 are dropped.
- wr_ptr is ADDR_W bits. Maximum count is 511, so no wrap-around occurs.
- i_Load_Start outside IDLE is ignored.
- Valid gaps of any length between bytes are allowed; the FSM waits indefinitely.
- Loader write and fetch read never coincide because fetch outputs NOP during hold.
- Reset mid-load: FSM returns to IDLE and o_Hold drops asynchronously. Words already written stay in RAM; no o_Load_Done pulse.

Optional Feature:
- Macro: LOAD_CHECKSUM_EN.
- Defined: after the last word (or after CNT_HI if count==0), state CHK accepts one byte. Expected byte = XOR of all preceding image bytes, counts included. On mismatch, o_Load_Error is set; it is sticky until the next accepted i_Load_Start or reset. o_Load_Done pulses regardless.
- Undefined: no CHK state, and o_Load_Error is tied to 0.

Test Plan:
- Reset, address 9'h005 -> o_Instruction=9'h000, o_Hold=0, o_Load_Ready=0.
- Start, then bytes 03,00, 11,01, 22,00, FF,01 -> RAM[0..2]=9'h111,9'h022,9'h1FF. o_Load_Done pulses once after the last byte. Then address 1 gives o_Instruction=9'h022 one cycle later.
- Count 00,00 -> o_Load_Done within 2 cycles of CNT_HI. RAM is unchanged, and o_Hold is high for start through DONE only.
- Load of 2 words with i_Load_Valid toggling every other cycle plus an extra i_Load_Start mid-load -> same RAM result as gap-free; the extra start is ignored.
- Reset after the first word of a 3-word load -> o_Hold=0 immediately, RAM[0] written, RAM[1] old value, no done pulse.
- LOAD_CHECKSUM_EN: image 01,00,AA,01 with checksum byte AA -> error=0. Same image with checksum 00 -> o_Load_Error=1 until the next start.
